// File: rtl/i2s_rx_stereo.sv
// Standard (Philips) I2S receiver: oversamples SCK/WS/SD in the clk_i domain and
// presents one signed left/right pair per complete stereo frame with a one-cycle strobe.
module i2s_rx_stereo #(
    parameter int SAMPLE_BITS   = 24,
    parameter int MIN_SLOT_BITS = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          i2s_sck_i,
    input  logic                          i2s_ws_i,
    input  logic                          i2s_sd_i,
    output logic                          sample_stb_o,
    output logic signed [SAMPLE_BITS-1:0] left_sample_o,
    output logic signed [SAMPLE_BITS-1:0] right_sample_o,
    output logic                          frame_err_o
);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    localparam logic [5:0] CNT_MAX    = 6'd63;
    localparam logic [5:0] SAMPLE_CNT = 6'(SAMPLE_BITS);
    localparam logic [5:0] MIN_CNT    = 6'(MIN_SLOT_BITS);

    // Writes one bit at its MSB-first position so a short slot is already left-justified.
    function automatic logic [SAMPLE_BITS-1:0] place_bit(input logic [SAMPLE_BITS-1:0] word,
                                                         input logic [5:0]             pos,
                                                         input logic                   bit_v);
        logic [SAMPLE_BITS-1:0] one_hot;
        one_hot = {{(SAMPLE_BITS-1){1'b0}}, bit_v} << (SAMPLE_CNT - 6'd1 - pos);
        return word | one_hot;
    endfunction

    logic sck_s1, sck_s2, sck_s3, ws_s1, ws_s2, sd_s1, sd_s2;
    logic rise, slot_end;
    logic ws_prev;
    logic [5:0] bit_cnt, cnt_inc;
    logic [SAMPLE_BITS-1:0] shreg, word_next;

    logic                   slot_end_p0, ws_now_p0;
    logic [5:0]             cnt_p0;
    logic [SAMPLE_BITS-1:0] word_p0;

    state_t                 state, state_d;
    logic                   commit_d, err_d, commit_p1;
    logic [SAMPLE_BITS-1:0] left_hold, right_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {sck_s1, sck_s2, sck_s3} <= 3'b000;
            {ws_s1, ws_s2}           <= 2'b00;
            {sd_s1, sd_s2}           <= 2'b00;
        end else begin
            sck_s1 <= i2s_sck_i;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            ws_s1  <= i2s_ws_i;
            ws_s2  <= ws_s1;
            sd_s1  <= i2s_sd_i;
            sd_s2  <= sd_s1;
        end
    end

    assign rise      = sck_s2 & ~sck_s3;
    assign slot_end  = rise & (ws_s2 != ws_prev);
    assign cnt_inc   = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 6'd1;
    assign word_next = (bit_cnt < SAMPLE_CNT) ? place_bit(shreg, bit_cnt, sd_s2) : shreg;

    // Stage p0: bit capture; a closing slot includes the bit taken at the same rise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ws_prev     <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            slot_end_p0 <= 1'b0;
            ws_now_p0   <= 1'b0;
            cnt_p0      <= '0;
            word_p0     <= '0;
        end else begin
            slot_end_p0 <= slot_end;
            if (rise) begin
                ws_prev <= ws_s2;
                if (slot_end) begin
                    bit_cnt   <= '0;
                    shreg     <= '0;
                    word_p0   <= word_next;
                    cnt_p0    <= cnt_inc;
                    ws_now_p0 <= ws_s2;
                end else begin
                    bit_cnt <= cnt_inc;
                    shreg   <= word_next;
                end
            end
        end
    end

    // Stage p1: frame FSM. SYNC waits for WS falling so the next slot is a left one.
    always_comb begin
        state_d  = state;
        commit_d = 1'b0;
        err_d    = 1'b0;
        case (state)
            SYNC: begin
                if (slot_end_p0 && !ws_now_p0) state_d = LEFT;
            end
            LEFT: begin
                if (slot_end_p0) begin
                    if (cnt_p0 < MIN_CNT) begin
                        err_d   = 1'b1;
                        state_d = SYNC;
                    end else begin
                        state_d = RIGHT;
                    end
                end
            end
            RIGHT: begin
                if (slot_end_p0) begin
                    if (cnt_p0 < MIN_CNT) begin
                        err_d   = 1'b1;
                        state_d = SYNC;
                    end else begin
                        commit_d = 1'b1;
                        state_d  = LEFT;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= SYNC;
            commit_p1   <= 1'b0;
            left_hold   <= '0;
            right_p1    <= '0;
            frame_err_o <= 1'b0;
        end else begin
            state     <= state_d;
            commit_p1 <= commit_d;
            if (slot_end_p0 && state == LEFT) left_hold <= word_p0;
            if (commit_d) right_p1 <= word_p0;
            if (err_d) frame_err_o <= 1'b1;
        end
    end

    // Stage p2: outputs move only together with the strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_stb_o   <= 1'b0;
            left_sample_o  <= '0;
            right_sample_o <= '0;
        end else begin
            sample_stb_o <= commit_p1;
            if (commit_p1) begin
                left_sample_o  <= left_hold;
                right_sample_o <= right_p1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Directed bench for i2s_rx_stereo: a frame table plus hand-written reset, resync
// and sustained-throughput sequences, all checked against hand-computed values.
module tb_i2s_rx_stereo;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic sck = 1'b0, ws = 1'b0, sd = 1'b0;
    logic sample_stb;
    logic signed [23:0] left_s, right_s;
    logic frame_err;

    int checks = 0;
    int failures = 0;

    i2s_rx_stereo #(.SAMPLE_BITS(24), .MIN_SLOT_BITS(16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .i2s_sck_i     (sck),
        .i2s_ws_i      (ws),
        .i2s_sd_i      (sd),
        .sample_stb_o  (sample_stb),
        .left_sample_o (left_s),
        .right_sample_o(right_s),
        .frame_err_o   (frame_err)
    );

    // 10-unit clk_i against an 88-unit SCK: about 8.8 clocks per bit, as at 27 MHz / 3.072 MHz.
    always #5 clk = ~clk;
    localparam int SCK_HALF = 44;

    int          stb_cnt = 0;
    logic [23:0] last_l = '0, last_r = '0;
    logic [23:0] got_l[$], got_r[$];
    logic        prev_stb = 1'b0, prev_rst = 1'b0;
    logic [23:0] prev_l = '0, prev_r = '0;
    logic        stb_wide = 1'b0, hold_bad = 1'b0;

    always @(negedge clk) begin
        if (sample_stb) begin
            stb_cnt = stb_cnt + 1;
            last_l  = left_s;
            last_r  = right_s;
            got_l.push_back(left_s);
            got_r.push_back(right_s);
            if (prev_stb) stb_wide = 1'b1;
        end else if (rst_ni && prev_rst && (left_s != prev_l || right_s != prev_r)) begin
            hold_bad = 1'b1;
        end
        prev_stb = sample_stb;
        prev_rst = rst_ni;
        prev_l   = left_s;
        prev_r   = right_s;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // WS runs one bit ahead: the slot's last bit is sent with the next channel's WS.
    task automatic send_part(input logic ch, input logic [31:0] word, input int n,
                             input int first, input int last);
        for (int i = first; i < last; i++) begin
            ws = (i == n - 1) ? ~ch : ch;
            sd = word[n-1-i];
            #SCK_HALF sck = 1'b1;
            #SCK_HALF sck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr);
        send_part(1'b0, l, nl, 0, nl);
        send_part(1'b1, r, nr, 0, nr);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] l;
        int          nl;
        logic [31:0] r;
        int          nr;
        int          exp_stb;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base;
        logic [31:0] tl[100], tr[100];

        vecs[0] = '{32'h123456A5, 32, 32'hABCDEF5A, 32, 0, 24'h000000, 24'h000000, 1'b0};
        vecs[1] = '{32'h1234563C, 32, 32'hABCDEFC3, 32, 1, 24'h123456, 24'hABCDEF, 1'b0};
        vecs[2] = '{32'h8000007E, 32, 32'hFFFFFF81, 32, 1, 24'h800000, 24'hFFFFFF, 1'b0};
        vecs[3] = '{32'h00007FFF, 16, 32'h00008001, 16, 1, 24'h7FFF00, 24'h800100, 1'b0};
        vecs[4] = '{32'h00000001, 24, 32'h007FFFFF, 24, 1, 24'h000001, 24'h7FFFFF, 1'b0};
        vecs[5] = '{32'h55555555, 32, 32'h000003FF, 10, 0, 24'h000000, 24'h000000, 1'b1};
        vecs[6] = '{32'h99999999, 32, 32'h66666666, 32, 0, 24'h000000, 24'h000000, 1'b1};
        vecs[7] = '{32'h0F0F0F00, 32, 32'hF0F0F0FF, 32, 1, 24'h0F0F0F, 24'hF0F0F0, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_stb", {31'h0, sample_stb}, 32'h0);
        check("reset_left", {8'h00, left_s}, 32'h0);
        check("reset_right", {8'h00, right_s}, 32'h0);
        check("reset_err", {31'h0, frame_err}, 32'h0);
        rst_ni = 1'b1;
        settle();

        for (int v = 0; v < 8; v++) begin
            base = stb_cnt;
            send_frame(vecs[v].l, vecs[v].nl, vecs[v].r, vecs[v].nr);
            settle();
            check($sformatf("vec%0d_strobes", v), stb_cnt - base, vecs[v].exp_stb);
            if (vecs[v].exp_stb != 0) begin
                check($sformatf("vec%0d_left", v), {8'h00, last_l}, {8'h00, vecs[v].exp_l});
                check($sformatf("vec%0d_right", v), {8'h00, last_r}, {8'h00, vecs[v].exp_r});
            end
            check($sformatf("vec%0d_err", v), {31'h0, frame_err}, {31'h0, vecs[v].exp_err});
        end

        // Reset in the middle of the right slot, then finish the slot with stale bits.
        send_part(1'b0, 32'h11111100, 32, 0, 32);
        send_part(1'b1, 32'h22222200, 32, 0, 16);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("midrst_left", {8'h00, left_s}, 32'h0);
        check("midrst_right", {8'h00, right_s}, 32'h0);
        check("midrst_err", {31'h0, frame_err}, 32'h0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        base = stb_cnt;
        send_part(1'b1, 32'h22222200, 32, 16, 32);
        settle();
        check("midrst_remnant_strobes", stb_cnt - base, 0);
        send_frame(32'h11111100, 32, 32'h22222200, 32);
        settle();
        check("midrst_fresh_strobes", stb_cnt - base, 1);
        check("midrst_fresh_left", {8'h00, last_l}, 32'h00111111);
        check("midrst_fresh_right", {8'h00, last_r}, 32'h00222222);
        check("midrst_fresh_err", {31'h0, frame_err}, 32'h0);

        // 100 back-to-back frames with random payloads.
        got_l.delete();
        got_r.delete();
        stb_wide = 1'b0;
        hold_bad = 1'b0;
        for (int f = 0; f < 100; f++) begin
            tl[f] = $urandom;
            tr[f] = $urandom;
            send_frame(tl[f], 32, tr[f], 32);
        end
        settle();
        check("tput_strobes", got_l.size(), 100);
        if (got_l.size() == 100) begin
            for (int f = 0; f < 100; f++) begin
                check($sformatf("tput_left%0d", f), {8'h00, got_l[f]}, {8'h00, tl[f][31:8]});
                check($sformatf("tput_right%0d", f), {8'h00, got_r[f]}, {8'h00, tr[f][31:8]});
            end
        end
        check("tput_stb_width", {31'h0, stb_wide}, 32'h0);
        check("tput_hold", {31'h0, hold_bad}, 32'h0);
        check("tput_err", {31'h0, frame_err}, 32'h0);

        // Idle SCK: nothing moves.
        base = stb_cnt;
        repeat (200) @(negedge clk);
        check("idle_strobes", stb_cnt - base, 0);
        check("idle_hold", {31'h0, hold_bad}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
